// File: rtl/bec_stream_loader.sv
`default_nettype none
// ============================================================================
// bec_stream_loader : host chunk stream -> BEC core operands/key, result -> host
// Rev 1.0
// ============================================================================
module bec_stream_loader #(
  parameter int DATA_W  = 163,
  parameter int HOST_W  = 32,
  parameter int NUM_OPS = 4,
  parameter int KEY_W   = 163,
  localparam int OPW    = $clog2(NUM_OPS + 1)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              abort_i,
  input  logic              host_valid_i,
  output logic              host_ready_o,
  input  logic [HOST_W-1:0] host_data_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [HOST_W-1:0] res_data_o,
  output logic              core_enable_o,
  output logic              core_load_o,
  output logic [OPW-1:0]    core_sel_o,
  output logic [DATA_W-1:0] core_data_o,
  output logic              core_ki_o,
  input  logic              core_next_key_i,
  input  logic              core_done_i,
  input  logic [DATA_W-1:0] core_data_i,
  output logic [2:0]        state_o
);

  localparam int CHUNKS = (DATA_W + HOST_W - 1) / HOST_W;
  localparam int AW     = CHUNKS * HOST_W;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int KW     = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    PUSH   = 3'd1,
    RUN    = 3'd2,
    UNLOAD = 3'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     c_q, c_d;
  logic [CW-1:0]     r_q, r_d;
  logic [OPW-1:0]    w_q, w_d;
  logic [KW-1:0]     k_q, k_d;
  logic              sat_q, sat_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] core_data_q, core_data_d;
  logic [AW-1:0]     asm_ext;
  logic [AW-1:0]     res_ext;
  logic [KW-1:0]     key_idx;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q     <= LOAD;
      c_q         <= '0;
      r_q         <= '0;
      w_q         <= '0;
      k_q         <= '0;
      sat_q       <= 1'b0;
      asm_q       <= '0;
      key_q       <= '0;
      result_q    <= '0;
      core_data_q <= '0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      r_q         <= r_d;
      w_q         <= w_d;
      k_q         <= k_d;
      sat_q       <= sat_d;
      asm_q       <= asm_d;
      key_q       <= key_d;
      result_q    <= result_d;
      core_data_q <= core_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    r_d         = r_q;
    w_d         = w_q;
    k_d         = k_q;
    sat_d       = sat_q;
    asm_d       = asm_q;
    key_d       = key_q;
    result_d    = result_q;
    core_data_d = core_data_q;
    asm_ext     = AW'(asm_q);

    case (state_q)
      LOAD: begin
        if (host_valid_i) begin
          // Chunk bits landing above DATA_W fall off in the truncation below.
          asm_ext[int'(c_q)*HOST_W +: HOST_W] = host_data_i;
          asm_d = asm_ext[DATA_W-1:0];
          if (c_q == CW'(CHUNKS - 1)) begin
            c_d = '0;
            if (w_q == OPW'(NUM_OPS)) begin
              key_d   = asm_d[KEY_W-1:0];
              k_d     = '0;
              sat_d   = 1'b0;
              state_d = RUN;
            end else begin
              core_data_d = asm_d;
              state_d     = PUSH;
            end
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      PUSH: begin
        w_d     = w_q + OPW'(1);
        state_d = LOAD;
      end
      RUN: begin
        if (core_done_i) begin
          result_d = core_data_i;
          r_d      = '0;
          state_d  = UNLOAD;
        end else if (core_next_key_i) begin
          if (k_q == KW'(KEY_W - 1)) sat_d = 1'b1;
          else                       k_d   = k_q + KW'(1);
        end
      end
      UNLOAD: begin
        if (res_ready_i) begin
          if (r_q == CW'(CHUNKS - 1)) begin
            r_d     = '0;
            w_d     = '0;
            state_d = LOAD;
          end else begin
            r_d = r_q + CW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase

    if (abort_i) begin
      state_d = LOAD;
      c_d     = '0;
      w_d     = '0;
      k_d     = '0;
      r_d     = '0;
      sat_d   = 1'b0;
    end
  end

  assign key_idx       = KW'(KEY_W - 1) - k_q;
  assign res_ext       = AW'(result_q);
  assign host_ready_o  = (state_q == LOAD);
  assign res_valid_o   = (state_q == UNLOAD);
  assign res_data_o    = (state_q == UNLOAD) ? res_ext[int'(r_q)*HOST_W +: HOST_W] : '0;
  assign core_enable_o = (state_q == RUN);
  assign core_load_o   = (state_q == PUSH);
  assign core_sel_o    = (state_q == PUSH) ? w_q : '0;
  assign core_data_o   = core_data_q;
  // Once the last key bit has been consumed the core sees zeros.
  assign core_ki_o     = (state_q == RUN) && !sat_q && key_q[key_idx];
  assign state_o       = state_q;

endmodule
`default_nettype wire
